// File: rtl/cmp64_sequencer.sv
// cmp64_sequencer
//   Two-pass 64-bit integer compare (eq / unsigned lt / signed lt) on a shared
//   32-bit subtract datapath. The low half runs first. The high half then runs
//   with the borrow chained in from the low half.
//
//   Optional feature macro: CMP_WORD_OP_EN
//     defined   : op_w_i selects a single-pass word compare on bits [31:0].
//     undefined : op_w_i is ignored and every compare takes the 64-bit path.
//
//   Ports
//     clk_i    rising-edge clock
//     rst_n_i  synchronous active-low reset
//     start_i  request; sampled only in IDLE or DONE
//     a_i/b_i  64-bit operands, latched on an accepted start
//     op_w_i   word-compare select, latched with the operands
//     busy_o   high in LOW and HIGH
//     done_o   one-cycle pulse; eq/lu/ls are valid in that cycle
//     eq_o     A == B
//     lu_o     A <  B unsigned
//     ls_o     A <  B signed
module cmp64_sequencer #(
  parameter int HALF = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [2*HALF-1:0] a_i,
  input  logic [2*HALF-1:0] b_i,
  input  logic              op_w_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              eq_o,
  output logic              lu_o,
  output logic              ls_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e          state_q;
  logic [2*HALF-1:0] a_q, b_q;
  logic            z_lo_q, c_lo_q;
  logic            busy_q, done_q, eq_q, lu_q, ls_q;

`ifdef CMP_WORD_OP_EN
  logic            opw_q;
`else
  logic            unused_opw;
  assign unused_opw = op_w_i;
`endif

  // Shared subtractor: a + ~b + carry_in, with carry-out meaning "no borrow".
  logic [HALF:0] lo_sum, hi_sum;
  assign lo_sum = {1'b0, a_q[HALF-1:0]} + {1'b0, ~b_q[HALF-1:0]} + {{HALF{1'b0}}, 1'b1};
  assign hi_sum = {1'b0, a_q[2*HALF-1:HALF]} + {1'b0, ~b_q[2*HALF-1:HALF]}
                + {{HALF{1'b0}}, c_lo_q};

  // 64-bit result from the HIGH pass combined with the registered low-pass zero flag.
  logic z64, lu64, ls64;
  assign z64  = z_lo_q & (hi_sum[HALF-1:0] == '0);
  assign lu64 = ~hi_sum[HALF] & ~z64;
  // Differing signs decide the signed order directly; otherwise the difference sign does.
  assign ls64 = (a_q[2*HALF-1] != b_q[2*HALF-1]) ? a_q[2*HALF-1] : (hi_sum[HALF-1] & ~z64);

`ifdef CMP_WORD_OP_EN
  logic zw, luw, lsw;
  assign zw  = (lo_sum[HALF-1:0] == '0);
  assign luw = ~lo_sum[HALF] & ~zw;
  assign lsw = (a_q[HALF-1] != b_q[HALF-1]) ? a_q[HALF-1] : (lo_sum[HALF-1] & ~zw);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z_lo_q  <= 1'b0;
      c_lo_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lu_q    <= 1'b0;
      ls_q    <= 1'b0;
`ifdef CMP_WORD_OP_EN
      opw_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
`ifdef CMP_WORD_OP_EN
            opw_q   <= op_w_i;
`endif
            state_q <= LOW;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        LOW: begin
          z_lo_q <= (lo_sum[HALF-1:0] == '0);
          c_lo_q <= lo_sum[HALF];
`ifdef CMP_WORD_OP_EN
          if (opw_q) begin
            eq_q    <= zw;
            lu_q    <= luw;
            ls_q    <= lsw;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= HIGH;
          end
`else
          state_q <= HIGH;
`endif
        end
        HIGH: begin
          eq_q    <= z64;
          lu_q    <= lu64;
          ls_q    <= ls64;
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign eq_o   = eq_q;
  assign lu_o   = lu_q;
  assign ls_o   = ls_q;

endmodule

// File: tb/tb_cmp64_sequencer.sv
// Directed bench for cmp64_sequencer: hand-computed expected results,
// latency and busy-length checks, handshake and reset-abort cases.
module tb_cmp64_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] a, b;
  logic        op_w;
  logic        busy, done, eq, lu, ls;

  int errs   = 0;
  int checks = 0;

  cmp64_sequencer dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .op_w_i (op_w),
    .busy_o (busy),
    .done_o (done),
    .eq_o   (eq),
    .lu_o   (lu),
    .ls_o   (ls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request and let the next rising edge sample it; returns #1 into cycle k+1.
  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic w);
    start = 1'b1; a = av; b = bv; op_w = w;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 into cycle k+1; walks to the done cycle and checks latency, busy length, results.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input logic e, input logic u, input logic s);
    int lat = 1;
    int bc  = 0;
    while (!done && lat < 8) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},  lat, exp_lat);
    chk({tag, ".busy"}, bc, exp_busy);
    chk({tag, ".busy_in_done"}, busy, 0);
    chk({tag, ".eq"}, eq, e);
    chk({tag, ".lu"}, lu, u);
    chk({tag, ".ls"}, ls, s);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; op_w = 1'b0;
    a = 64'h0000_0000_0000_0001; b = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset held for two edges with start asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.res", {eq, lu, ls}, 0);
    end

    // First start sampled with reset released: unsigned/signed split.
    @(negedge clk); rst_n = 1'b1;
    issue(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done("split", 3, 2, 0, 1, 0);
    @(posedge clk); #1;
    chk("split.pulse", done, 0);
    chk("split.hold", {eq, lu, ls}, 3'b010);

    // Borrow chain across the halves, both orders.
    @(negedge clk);
    issue(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0);
    wait_done("borrow", 3, 2, 0, 0, 0);
    @(negedge clk);
    issue(64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0);
    wait_done("borrow_sw", 3, 2, 0, 1, 1);

    // Two negatives.
    @(negedge clk);
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done("neg", 3, 2, 0, 1, 1);

    // Equality, then a back-to-back start in the DONE cycle.
    @(negedge clk);
    issue(64'h8000_0000_1234_5678, 64'h8000_0000_1234_5678, 1'b0);
    wait_done("equal", 3, 2, 1, 0, 0);
    issue(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_done("b2b", 3, 2, 0, 1, 0);

    // Word mode: low words 0x80000000 vs 1.
    @(negedge clk);
    issue(64'h0000_0001_8000_0000, 64'h0000_0000_0000_0001, 1'b1);
`ifdef CMP_WORD_OP_EN
    wait_done("word", 2, 1, 0, 0, 1);
`else
    wait_done("word_off", 3, 2, 0, 0, 0);
`endif

    // Start while busy is dropped and does not disturb the latched operands.
    @(negedge clk);
    issue(64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0);
    start = 1'b1; a = 64'h5; b = 64'h5; op_w = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign.done", done, 1);
    chk("ign.res", {eq, lu, ls}, 3'b011);
    @(posedge clk); #1;
    chk("ign.noq_done", done, 0);
    chk("ign.noq_busy", busy, 0);

    // Reset during HIGH aborts and clears the held results.
    @(negedge clk);
    issue(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    chk("abort.in_high", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.done", done, 0);
    chk("abort.busy", busy, 0);
    chk("abort.res", {eq, lu, ls}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort.quiet", {done, busy}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cmp64_sequencer.md
# cmp64_sequencer

Multi-cycle controller that performs 64-bit RV64 integer comparisons (equal, unsigned less-than, signed less-than) by running a 32-bit subtract/compare datapath twice: low half first, then high half with the borrow chained. It sits between the integer issue logic (branch resolution, SLT/SLTU/SLTI) and the shared 32-bit comparison datapath. It sequences the two passes with an FSM and presents results through a start/done handshake. A single-pass word mode serves the RV64 W-suffixed compare paths.

## Interface
- HALF, 32, width of one datapath pass; the operand width is 2*HALF.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- a  input  64  operand A; captured on an accepted start.
- b  input  64  operand B; captured on an accepted start.
- op_w  input  1  word compare on a[31:0] and b[31:0] only; captured with the operands.
- busy  output  1  high in LOW and HIGH.
- done  output  1  one-cycle pulse; results are valid in that cycle.
- eq  output  1  A == B.
- lu  output  1  A < B, unsigned.
- ls  output  1  A < B, signed.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- Transitions:
  - IDLE goes to LOW on start.
  - LOW goes to DONE if the latched op_w is 1, otherwise to HIGH.
  - HIGH goes to DONE.
  - DONE goes to LOW on start, otherwise to IDLE.
- Accepted start: latch a, b and op_w into internal registers. Live inputs are ignored until the next accepted start.
- start is ignored while busy. No queueing; a dropped start must be reissued by the requester.
- LOW pass:
  - Compute {c_lo, s_lo} = a_r[31:0] + ~b_r[31:0] + 1, a 33-bit result.
  - Register z_lo = (s_lo == 0), c_lo, s_lo[31], a_r[31] and b_r[31].
- HIGH pass:
  - Compute {c_hi, s_hi} = a_r[63:32] + ~b_r[63:32] + c_lo.
  - Register z_hi = (s_hi == 0) and c_hi.
- Result formulas. For 64-bit, use z = z_lo & z_hi, C = c_hi, sign bits a_r[63], b_r[63], s_hi[31]. For word, use z = z_lo, C = c_lo, sign bits a_r[31], b_r[31], s_lo[31].
  - eq = z.
  - lu = ~C & ~z.
  - ls = (A_s != B_s) ? A_s : (S_s & ~z).
- eq, lu and ls are registered. They update on entry to DONE and hold until the next DONE. They do not clear in IDLE.

## Timing
- Reset (rst_n low at a rising edge): state becomes IDLE. busy, done, eq, lu and ls are all 0. Operand registers are cleared.
- Reset mid-operation aborts the compare with no done pulse and no result update.
- Start sampled at edge k:
  - 64-bit compare: LOW in cycle k+1, HIGH in cycle k+2, done=1 in cycle k+3.
  - Word compare: done=1 in cycle k+2.
- Back-to-back: start asserted during DONE is accepted. The next done then follows at the same latency, giving a throughput of one 64-bit compare every 3 cycles.
- done is high for exactly one cycle per accepted start. done and busy are never high together.
- busy is high in cycles k+1..k+2 for 64-bit and k+1 only for word.

## Configuration
- CMP_WORD_OP_EN defined: op_w is honoured, including the LOW-to-DONE shortcut and the 32-bit result formulas.
- CMP_WORD_OP_EN undefined: op_w is ignored (latched as 0). Every compare takes the 64-bit path with 3-cycle latency, and no word-mode logic is synthesized.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=done=eq=lu=ls=0. The first done follows exactly 3 cycles after the first start sampled with rst_n=1.
- Unsigned/signed split: a=0x0000_0000_0000_0001, b=0xFFFF_FFFF_FFFF_FFFF, op_w=0 -> done at k+3 with eq=0, lu=1, ls=0.
- Borrow chain: a=0x0000_0001_0000_0000, b=0x0000_0000_FFFF_FFFF -> eq=0, lu=0, ls=0. Swapping the operands -> lu=1, ls=1.
- Equality: a=b=0x8000_0000_1234_5678 -> eq=1, lu=0, ls=0.
- Word mode (CMP_WORD_OP_EN defined): a=0x0000_0001_8000_0000, b=0x0000_0000_0000_0001, op_w=1 -> done at k+2 with eq=0, lu=0, ls=1, and busy high for only one cycle.
- Handshake: pulse start again in the DONE cycle -> accepted, next done 3 cycles later. Pulse start while busy -> ignored, and the latched operands are unchanged. Pull rst_n=0 during HIGH -> no done pulse and the previous eq/lu/ls values are cleared to 0.
